apb_to_axi_bridge: RTL and testbench
====================================

APB_TO_AXI_BRIDGE -- requirements
Module: apb_to_axi_bridge

Interface
REQ-001 Parameter AXI_ID, default 6'h00: ID driven on AWID, WID and ARID.
REQ-002 Parameter ADDR_OFFSET, default 32'h0000_0000: added modulo 2^32 to PADDR to form the AXI address.
REQ-003 One clock; reset is synchronous and active-high: ports ACLK and ARESET.
REQ-004 ACLK  in  1  clock.
REQ-005 ARESET  in  1  synchronous active-high reset.
REQ-006 PSEL, PENABLE, PWRITE  in  1 each  APB slave control.
REQ-007 PADDR  in  32  APB address; PWDATA  in  32  APB write data.
REQ-008 PRDATA  out  32  read data; PREADY  out  1  transfer complete; PSLVERR  out  1  error.
REQ-009 AWID  out  6; AWADDR  out  32; AWLEN  out  4; AWSIZE  out  3; AWBURST  out  2; AWVALID  out  1; AWREADY  in  1.
REQ-010 WID  out  6; WDATA  out  64; WSTRB  out  8; WLAST  out  1; WVALID  out  1; WREADY  in  1.
REQ-011 BID  in  6; BRESP  in  2; BVALID  in  1; BREADY  out  1.
REQ-012 ARID  out  6; ARADDR  out  32; ARLEN  out  4; ARSIZE  out  3; ARBURST  out  2; ARVALID  out  1; ARREADY  in  1.
REQ-013 RID  in  6; RDATA  in  64; RRESP  in  2; RLAST  in  1; RVALID  in  1; RREADY  out  1.

Function
REQ-014 All outputs SHALL be registered; one AXI transaction outstanding at most.
REQ-015 Burst fields constant: AWLEN/ARLEN = 4'h0, AWSIZE/ARSIZE = 3'b010, AWBURST/ARBURST = 2'b01, WLAST = 1.
REQ-016 AWADDR/ARADDR = {(PADDR+ADDR_OFFSET)[31:2], 2'b00}, captured in the APB setup phase.
REQ-017 Write lanes: lane = captured address bit 2; WDATA = {PWDATA, PWDATA}; WSTRB = 8'h0F if lane 0, 8'hF0 if lane 1.
REQ-018 Read lanes: PRDATA = RDATA[31:0] if lane 0, RDATA[63:32] if lane 1, captured on the R handshake.
REQ-019 FSM states: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE.
REQ-020 IDLE: PSEL=1 & PENABLE=0 captures PADDR/PWDATA/PWRITE and goes to WR_ADDR (PWRITE=1) or RD_ADDR (PWRITE=0); PSEL&PENABLE in IDLE is ignored.
REQ-021 WR_ADDR: AWVALID and WVALID asserted; each drops independently after its own handshake; go to WR_RESP after both complete, whether simultaneously or in either order.
REQ-022 WR_RESP: BREADY=1; on BVALID go to DONE.
REQ-023 RD_ADDR: ARVALID=1; on ARREADY go to RD_DATA.
REQ-024 RD_DATA: RREADY=1; on RVALID go to DONE.
REQ-025 Valid signals stay asserted, with payload stable, until the handshake completes; they never depend on AXI ready inputs.
REQ-026 DONE: PREADY=1 for exactly one cycle, then IDLE; PREADY=0 in all other states.
REQ-027 PSLVERR = 1 in DONE when the captured BRESP/RRESP bit 1 = 1 (SLVERR/DECERR), or BID/RID != AXI_ID, or RLAST = 0; otherwise 0. Valid only while PREADY=1.
REQ-028 Minimum latency: setup at cycle T; PREADY at T+3 when all AXI readies and responses are immediate.
REQ-029 PRDATA holds its last value outside reads; after write transfers it is 32'h0.

Reset
REQ-030 ARESET=1 at a rising ACLK edge forces IDLE, from any state including a pending handshake.
REQ-031 Reset values: AWVALID, WVALID, ARVALID, BREADY, RREADY, PREADY, PSLVERR = 0; PRDATA, AWADDR, ARADDR, WDATA = 0; WSTRB = 8'h00.
REQ-032 An AXI response arriving in IDLE after reset SHALL be ignored; BREADY and RREADY stay low.

Structure
REQ-033 The shared package apb_axi_pkg SHALL hold the state enum, AXI_SIZE_4B, AXI_BURST_INCR, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR, and the data and ID widths.
REQ-034 The design is a single module; no sub-module is required.

Verification
REQ-035 Write to 0x0000_0004 with data 0xDEADBEEF and all readies high -> AWADDR 0x0000_0004, WDATA 0xDEADBEEF_DEADBEEF, WSTRB 0xF0, PREADY at T+3, PSLVERR=0.
REQ-036 Read from 0x10 with RDATA=0x11223344_55667788 and 5-cycle ARREADY/RVALID delays -> PRDATA 0x55667788, PREADY one cycle only.
REQ-037 WREADY 3 cycles before AWREADY, then reverse order -> single AW and single W handshake each, WVALID stable until accepted.
REQ-038 BRESP=2'b10, then RID=6'h05 with AXI_ID=0 -> PSLVERR=1 with PREADY in both cases.
REQ-039 ARESET asserted while in WR_ADDR with AWREADY low -> all valids low next cycle, IDLE, and the next transfer completes normally.
REQ-040 ADDR_OFFSET=32'hFFFF_FFF8 with PADDR 0x10 -> ARADDR 0x0000_0008, showing wrap-around.

Source files
------------

// File: rtl/apb_axi_pkg.sv
// ============================================================================
// Module      : apb_axi_pkg
// Description : Shared types and constants for the APB-to-AXI bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_axi_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int AXI_DATA_W = 64;
    localparam int STRB_W     = AXI_DATA_W / 8;
    localparam int ID_W       = 6;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5
    } state_e;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/apb_to_axi_bridge.sv
// ============================================================================
// Module      : apb_to_axi_bridge
// Description : APB slave to single-beat AXI3 master, one transfer in flight.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_to_axi_bridge
    import apb_axi_pkg::*;
#(
    parameter logic [ID_W-1:0]   AXI_ID      = 6'h00,
    parameter logic [ADDR_W-1:0] ADDR_OFFSET = 32'h0000_0000
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_W-1:0]     PADDR,
    input  logic [DATA_W-1:0]     PWDATA,
    output logic [DATA_W-1:0]     PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [ID_W-1:0]       AWID,
    output logic [ADDR_W-1:0]     AWADDR,
    output logic [3:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic [1:0]            AWBURST,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [ID_W-1:0]       WID,
    output logic [AXI_DATA_W-1:0] WDATA,
    output logic [STRB_W-1:0]     WSTRB,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [ID_W-1:0]       BID,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ID_W-1:0]       ARID,
    output logic [ADDR_W-1:0]     ARADDR,
    output logic [3:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic [1:0]            ARBURST,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [ID_W-1:0]       RID,
    input  logic [AXI_DATA_W-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY
);

    state_e                  state_q,   state_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q,  wvalid_d;
    logic                    arvalid_q, arvalid_d;
    logic                    bready_q,  bready_d;
    logic                    rready_q,  rready_d;
    logic                    pready_q,  pready_d;
    logic                    pslverr_q, pslverr_d;
    logic                    lane_q,    lane_d;
    logic [DATA_W-1:0]       prdata_q,  prdata_d;
    logic [ADDR_W-1:0]       awaddr_q,  awaddr_d;
    logic [ADDR_W-1:0]       araddr_q,  araddr_d;
    logic [AXI_DATA_W-1:0]   wdata_q,   wdata_d;
    logic [STRB_W-1:0]       wstrb_q,   wstrb_d;

    logic [ADDR_W-1:0]       w_addr_sum;
    logic [ADDR_W-1:0]       w_addr_aligned;
    logic                    w_aw_done;
    logic                    w_w_done;

    assign w_addr_sum     = PADDR + ADDR_OFFSET;
    assign w_addr_aligned = w_addr_sum & ~32'h0000_0003;

    // A channel counts as complete once its valid has already dropped or its handshake is happening now.
    assign w_aw_done = !awvalid_q || AWREADY;
    assign w_w_done  = !wvalid_q  || WREADY;

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        bready_d  = 1'b0;
        rready_d  = 1'b0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        lane_d    = lane_q;
        prdata_d  = prdata_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;

        unique case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    lane_d = w_addr_sum[2];
                    if (PWRITE) begin
                        awaddr_d  = w_addr_aligned;
                        wdata_d   = {PWDATA, PWDATA};
                        wstrb_d   = w_addr_sum[2] ? 8'hF0 : 8'h0F;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_ADDR;
                    end else begin
                        araddr_d  = w_addr_aligned;
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            WR_ADDR: begin
                if (awvalid_q && AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && WREADY)   wvalid_d  = 1'b0;
                if (w_aw_done && w_w_done) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (BVALID) begin
                    pready_d  = 1'b1;
                    pslverr_d = resp_is_err(BRESP) || (BID != AXI_ID);
                    prdata_d  = '0;
                    state_d   = DONE;
                end else begin
                    bready_d = 1'b1;
                end
            end
            RD_ADDR: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (RVALID) begin
                    pready_d  = 1'b1;
                    pslverr_d = resp_is_err(RRESP) || (RID != AXI_ID) || !RLAST;
                    prdata_d  = lane_q ? RDATA[63:32] : RDATA[31:0];
                    state_d   = DONE;
                end else begin
                    rready_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            lane_q    <= 1'b0;
            prdata_q  <= '0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            lane_q    <= lane_d;
            prdata_q  <= prdata_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

    assign AWID    = AXI_ID;
    assign AWADDR  = awaddr_q;
    assign AWLEN   = 4'h0;
    assign AWSIZE  = AXI_SIZE_4B;
    assign AWBURST = AXI_BURST_INCR;
    assign AWVALID = awvalid_q;

    assign WID     = AXI_ID;
    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign WLAST   = 1'b1;
    assign WVALID  = wvalid_q;

    assign BREADY  = bready_q;

    assign ARID    = AXI_ID;
    assign ARADDR  = araddr_q;
    assign ARLEN   = 4'h0;
    assign ARSIZE  = AXI_SIZE_4B;
    assign ARBURST = AXI_BURST_INCR;
    assign ARVALID = arvalid_q;

    assign RREADY  = rready_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_to_axi_bridge.sv
// ============================================================================
// Module      : tb_apb_to_axi_bridge
// Description : Self-checking bench for apb_to_axi_bridge with a delay-programmable AXI slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_to_axi_bridge;

    logic        ACLK, ARESET;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic        AWREADY, WREADY, ARREADY, BVALID, RVALID, RLAST;
    logic [5:0]  BID, RID;
    logic [1:0]  BRESP, RRESP;
    logic [63:0] RDATA;

    logic [31:0] PRDATA, AWADDR, ARADDR;
    logic        PREADY, PSLVERR, AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY;
    logic [5:0]  AWID, WID, ARID;
    logic [3:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;

    // Second instance with a wrapping offset, fed identical stimulus.
    logic [31:0] PRDATA2, AWADDR2, ARADDR2;
    logic        PREADY2, PSLVERR2, AWVALID2, WVALID2, WLAST2, BREADY2, ARVALID2, RREADY2;
    logic [5:0]  AWID2, WID2, ARID2;
    logic [3:0]  AWLEN2, ARLEN2;
    logic [2:0]  AWSIZE2, ARSIZE2;
    logic [1:0]  AWBURST2, ARBURST2;
    logic [63:0] WDATA2;
    logic [7:0]  WSTRB2;

    apb_to_axi_bridge dut (
        .ACLK(ACLK), .ARESET(ARESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB),
        .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY), .BID(BID), .BRESP(BRESP),
        .BVALID(BVALID), .BREADY(BREADY), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    apb_to_axi_bridge #(.AXI_ID(6'h00), .ADDR_OFFSET(32'hFFFF_FFF8)) dut2 (
        .ACLK(ACLK), .ARESET(ARESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA2), .PREADY(PREADY2), .PSLVERR(PSLVERR2),
        .AWID(AWID2), .AWADDR(AWADDR2), .AWLEN(AWLEN2), .AWSIZE(AWSIZE2), .AWBURST(AWBURST2),
        .AWVALID(AWVALID2), .AWREADY(AWREADY), .WID(WID2), .WDATA(WDATA2), .WSTRB(WSTRB2),
        .WLAST(WLAST2), .WVALID(WVALID2), .WREADY(WREADY), .BID(BID), .BRESP(BRESP),
        .BVALID(BVALID), .BREADY(BREADY2), .ARID(ARID2), .ARADDR(ARADDR2), .ARLEN(ARLEN2),
        .ARSIZE(ARSIZE2), .ARBURST(ARBURST2), .ARVALID(ARVALID2), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY2)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        logic        wr;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic [63:0] rdata;
        logic [1:0]  bresp;
        logic [1:0]  rresp;
        logic [5:0]  bid;
        logic [5:0]  rid;
        logic        rlast;
        int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
        logic [31:0] exp_addr;
        logic [31:0] exp_prdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] addr2;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [31:0] prdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[12];

    int checks = 0;
    int errors = 0;

    // Slave configuration, written by the stimulus tasks
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic stray = 1'b0;
    int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;

    // Monitor state
    int aw_hs = 0, w_hs = 0, ar_hs = 0, proto_err = 0;
    logic [31:0] mon_addr = '0, mon_addr2 = '0;
    logic [63:0] mon_wdata = '0;
    logic [7:0]  mon_wstrb = '0;
    logic        p_aw = 0, p_w = 0, p_ar = 0, rst_p = 1;
    logic [31:0] p_awaddr = '0, p_araddr = '0;
    logic [63:0] p_wdata = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    always @(negedge ACLK) begin
        aw_wait = AWVALID ? aw_wait + 1 : 0;
        w_wait  = WVALID  ? w_wait  + 1 : 0;
        ar_wait = ARVALID ? ar_wait + 1 : 0;
        b_wait  = BREADY  ? b_wait  + 1 : 0;
        r_wait  = RREADY  ? r_wait  + 1 : 0;
        AWREADY = AWVALID && (aw_wait > aw_dly);
        WREADY  = WVALID  && (w_wait  > w_dly);
        ARREADY = ARVALID && (ar_wait > ar_dly);
        BVALID  = stray || (BREADY && (b_wait > b_dly));
        RVALID  = stray || (RREADY && (r_wait > r_dly));
    end

    always @(posedge ACLK) begin
        if (AWVALID && AWREADY) begin
            aw_hs++;
            mon_addr  = AWADDR;
            mon_addr2 = AWADDR2;
            if (AWLEN !== 4'h0 || AWSIZE !== 3'b010 || AWBURST !== 2'b01 || AWID !== 6'h00)
                proto_err++;
        end
        if (WVALID && WREADY) begin
            w_hs++;
            mon_wdata = WDATA;
            mon_wstrb = WSTRB;
            if (WLAST !== 1'b1 || WID !== 6'h00) proto_err++;
        end
        if (ARVALID && ARREADY) begin
            ar_hs++;
            mon_addr  = ARADDR;
            mon_addr2 = ARADDR2;
            if (ARLEN !== 4'h0 || ARSIZE !== 3'b010 || ARBURST !== 2'b01 || ARID !== 6'h00)
                proto_err++;
        end
        if (!rst_p) begin
            if (p_aw && (!AWVALID || AWADDR !== p_awaddr)) proto_err++;
            if (p_w  && (!WVALID  || WDATA  !== p_wdata))  proto_err++;
            if (p_ar && (!ARVALID || ARADDR !== p_araddr)) proto_err++;
        end
        p_aw     = AWVALID && !AWREADY;
        p_w      = WVALID  && !WREADY;
        p_ar     = ARVALID && !ARREADY;
        p_awaddr = AWADDR;
        p_wdata  = WDATA;
        p_araddr = ARADDR;
        rst_p    = ARESET;
    end

    function automatic vec_t mk(input logic wr, input logic [31:0] paddr, input logic [31:0] pwdata,
                                input logic [63:0] rdata, input logic [1:0] bresp, input logic [1:0] rresp,
                                input logic [5:0] bid, input logic [5:0] rid, input logic rlast,
                                input int awd, input int wd, input int bd, input int ard, input int rd,
                                input logic [31:0] ea, input logic [31:0] ep, input logic ee, input int el);
        vec_t v;
        v.wr = wr; v.paddr = paddr; v.pwdata = pwdata; v.rdata = rdata;
        v.bresp = bresp; v.rresp = rresp; v.bid = bid; v.rid = rid; v.rlast = rlast;
        v.aw_dly = awd; v.w_dly = wd; v.b_dly = bd; v.ar_dly = ard; v.r_dly = rd;
        v.exp_addr = ea; v.exp_prdata = ep; v.exp_err = ee; v.exp_lat = el;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        exp_t e;
        int   n;
        int   aw0, w0, ar0, pe0;
        aw_dly = v.aw_dly; w_dly = v.w_dly; b_dly = v.b_dly; ar_dly = v.ar_dly; r_dly = v.r_dly;
        RDATA = v.rdata; BRESP = v.bresp; RRESP = v.rresp; BID = v.bid; RID = v.rid; RLAST = v.rlast;
        @(negedge ACLK);
        aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs; pe0 = proto_err;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = v.wr; PADDR = v.paddr; PWDATA = v.pwdata;
        e.wr     = v.wr;
        e.addr   = v.exp_addr;
        e.addr2  = (v.paddr + 32'hFFFF_FFF8) & ~32'h3;
        e.wdata  = {v.pwdata, v.pwdata};
        e.wstrb  = v.exp_addr[2] ? 8'hF0 : 8'h0F;
        e.prdata = v.exp_prdata;
        e.err    = v.exp_err;
        sb.push_back(e);
        @(negedge ACLK);
        PENABLE = 1'b1;
        n = 1;
        while (!PREADY && n < 60) begin
            @(negedge ACLK);
            n++;
        end
        e = sb.pop_front();
        if (!PREADY) begin
            chk({tag, "_timeout_pready"}, {63'd0, PREADY}, 64'd1);
        end else begin
            chk({tag, "_prdata"},  {32'd0, PRDATA}, {32'd0, e.prdata});
            chk({tag, "_pslverr"}, {63'd0, PSLVERR}, {63'd0, e.err});
            chk({tag, "_addr"},    {32'd0, mon_addr}, {32'd0, e.addr});
            chk({tag, "_addr_wrap"}, {32'd0, mon_addr2}, {32'd0, e.addr2});
            chk({tag, "_pready2"}, {63'd0, PREADY2}, 64'd1);
            if (v.exp_lat != 0) chk({tag, "_latency"}, 64'(n), 64'(v.exp_lat));
            if (e.wr) begin
                chk({tag, "_wdata"}, mon_wdata, e.wdata);
                chk({tag, "_wstrb"}, {56'd0, mon_wstrb}, {56'd0, e.wstrb});
            end
            chk({tag, "_aw_hs"}, 64'(aw_hs - aw0), e.wr ? 64'd1 : 64'd0);
            chk({tag, "_w_hs"},  64'(w_hs - w0),   e.wr ? 64'd1 : 64'd0);
            chk({tag, "_ar_hs"}, 64'(ar_hs - ar0), e.wr ? 64'd0 : 64'd1);
            chk({tag, "_protocol"}, 64'(proto_err - pe0), 64'd0);
        end
        @(negedge ACLK);
        chk({tag, "_pready_one_cycle"}, {63'd0, PREADY}, 64'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk(1, 32'h04, 32'hDEADBEEF, 64'h0, 2'b00, 2'b00, 6'h00, 6'h00, 1, 0, 0, 0, 0, 0,
                      32'h04, 32'h0, 0, 3);
        vecs[1]  = mk(0, 32'h10, 32'h0, 64'h11223344_55667788, 2'b00, 2'b00, 6'h00, 6'h00, 1, 0, 0, 0, 5, 5,
                      32'h10, 32'h55667788, 0, 0);
        vecs[2]  = mk(0, 32'h14, 32'h0, 64'h11223344_55667788, 2'b00, 2'b00, 6'h00, 6'h00, 1, 0, 0, 0, 0, 0,
                      32'h14, 32'h11223344, 0, 3);
        vecs[3]  = mk(1, 32'h08, 32'h0BADF00D, 64'h0, 2'b00, 2'b00, 6'h00, 6'h00, 1, 3, 0, 0, 0, 0,
                      32'h08, 32'h0, 0, 0);
        vecs[4]  = mk(1, 32'h0C, 32'h12345678, 64'h0, 2'b00, 2'b00, 6'h00, 6'h00, 1, 0, 3, 0, 0, 0,
                      32'h0C, 32'h0, 0, 0);
        vecs[5]  = mk(1, 32'h20, 32'hA0A0A0A0, 64'h0, 2'b10, 2'b00, 6'h00, 6'h00, 1, 0, 0, 0, 0, 0,
                      32'h20, 32'h0, 1, 3);
        vecs[6]  = mk(0, 32'h30, 32'h0, 64'hA5A5A5A5_5A5A5A5A, 2'b00, 2'b00, 6'h00, 6'h05, 1, 0, 0, 0, 0, 0,
                      32'h30, 32'h5A5A5A5A, 1, 3);
        vecs[7]  = mk(0, 32'h37, 32'h0, 64'hCAFEF00D_01020304, 2'b00, 2'b00, 6'h00, 6'h00, 0, 0, 0, 0, 1, 2,
                      32'h34, 32'hCAFEF00D, 1, 0);
        vecs[8]  = mk(1, 32'h43, 32'h13572468, 64'h0, 2'b00, 2'b00, 6'h03, 6'h00, 1, 0, 0, 0, 0, 0,
                      32'h40, 32'h0, 1, 3);
        vecs[9]  = mk(0, 32'h18, 32'h0, 64'hFFFF0000_0000FFFF, 2'b00, 2'b01, 6'h00, 6'h00, 1, 0, 0, 0, 0, 0,
                      32'h18, 32'h0000FFFF, 0, 3);
        vecs[10] = mk(1, 32'h1C, 32'h0F0F0F0F, 64'h0, 2'b11, 2'b00, 6'h00, 6'h00, 1, 0, 0, 4, 0, 0,
                      32'h1C, 32'h0, 1, 0);
        vecs[11] = mk(0, 32'h10, 32'h0, 64'h11223344_55667788, 2'b00, 2'b11, 6'h00, 6'h00, 1, 0, 0, 0, 0, 0,
                      32'h10, 32'h55667788, 1, 3);

        ARESET = 1'b1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
        BID = '0; RID = '0; BRESP = '0; RRESP = '0; RDATA = '0; RLAST = 1'b1;
        AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
        repeat (3) @(negedge ACLK);
        chk("reset_ctrl", {58'd0, AWVALID, WVALID, ARVALID, BREADY, RREADY, PREADY}, 64'd0);
        chk("reset_pslverr", {63'd0, PSLVERR}, 64'd0);
        chk("reset_prdata", {32'd0, PRDATA}, 64'd0);
        chk("reset_addr", {AWADDR, ARADDR}, 64'd0);
        chk("reset_wdata", WDATA, 64'd0);
        chk("reset_wstrb", {56'd0, WSTRB}, 64'd0);
        ARESET = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Reset while the address channel is stalled
        aw_dly = 30; w_dly = 0;
        @(negedge ACLK);
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h50; PWDATA = 32'h55AA55AA;
        @(negedge ACLK);
        PENABLE = 1;
        @(negedge ACLK);
        chk("midrst_awvalid_before", {63'd0, AWVALID}, 64'd1);
        ARESET = 1'b1;
        @(negedge ACLK);
        chk("midrst_valids", {58'd0, AWVALID, WVALID, ARVALID, BREADY, RREADY, PREADY}, 64'd0);
        ARESET = 1'b0; PSEL = 0; PENABLE = 0;

        // Responses presented while idle must not be accepted
        stray = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            chk($sformatf("stray_%0d", k), {61'd0, BREADY, RREADY, PREADY}, 64'd0);
        end
        stray = 1'b0;
        @(negedge ACLK);

        run_vec(vecs[0], "post_reset_wr");
        run_vec(vecs[2], "post_reset_rd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
